// File: rtl/maxi4_rd_splitter.sv
// AXI4 read master: splits one word-count read command into AR bursts
// (max burst length, 4KB pages) and streams R data back with a command last.
module maxi4_rd_splitter #(
    parameter int AXI4_DATA_W = 512,
    parameter int AXI4_ADD_W  = 64,
    parameter int AXI4_ID_W   = 8,
    parameter int AXI4_ID     = 1,
    parameter int WORD_NB_W   = 32,
    parameter int OUTSTD_MAX  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_vld,
    output logic                   cmd_rdy,
    input  logic [AXI4_ADD_W-1:0]  cmd_addr,
    input  logic [WORD_NB_W-1:0]   cmd_word_nb,
    output logic [AXI4_ID_W-1:0]   arid,
    output logic [AXI4_ADD_W-1:0]  araddr,
    output logic [7:0]             arlen,
    output logic [2:0]             arsize,
    output logic [1:0]             arburst,
    output logic                   arvalid,
    input  logic                   arready,
    input  logic [AXI4_ID_W-1:0]   rid,
    input  logic [AXI4_DATA_W-1:0] rdata,
    input  logic [1:0]             rresp,
    input  logic                   rlast,
    input  logic                   rvalid,
    output logic                   rready,
    output logic [AXI4_DATA_W-1:0] out_data,
    output logic                   out_last,
    output logic                   out_vld,
    input  logic                   out_rdy,
    output logic                   err,
    output logic                   busy
);

    localparam int AXI4_DATA_BYTES = AXI4_DATA_W / 8;
    localparam int PAGE_WORDS = 4096 / AXI4_DATA_BYTES;
    localparam int AXI4_LEN_MAX = ((PAGE_WORDS < 256) ? PAGE_WORDS : 256) - 1;
    localparam int SIZE = $clog2(AXI4_DATA_BYTES);
    localparam int OUT_W = $clog2(OUTSTD_MAX + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

    state_e                  state_q, state_d;
    logic [AXI4_ADD_W-1:0]   iss_addr_q, iss_addr_d;
    logic [WORD_NB_W-1:0]    iss_rmn_q, iss_rmn_d;
    logic [WORD_NB_W-1:0]    rsp_rmn_q, rsp_rmn_d;
    logic [OUT_W-1:0]        outstd_q, outstd_d;
    logic                    arvalid_q, arvalid_d;
    logic [AXI4_ADD_W-1:0]   araddr_q, araddr_d;
    logic [7:0]              arlen_q, arlen_d;
    logic                    err_q, err_d;
    logic                    load;
    logic [12:0]             page;
    logic [12:0]             lim;
    logic [8:0]              blen;

    logic ar_hs;
    logic r_hs;
    logic rl_hs;
    logic unused_rid;

    assign ar_hs = arvalid_q & arready;
    assign r_hs  = rvalid & out_rdy;
    assign rl_hs = r_hs & rlast & (outstd_q != '0);
    assign unused_rid = ^rid;

    assign arid    = AXI4_ID_W'(AXI4_ID);
    assign arsize  = 3'(SIZE);
    assign arburst = 2'b01;
    assign arvalid = arvalid_q;
    assign araddr  = araddr_q;
    assign arlen   = arlen_q;

    assign out_data = rdata;
    assign out_vld  = rvalid;
    assign rready   = out_rdy;
    assign out_last = rvalid & (rsp_rmn_q == WORD_NB_W'(1));

    assign err     = err_q;
    assign busy    = (state_q != IDLE);
    assign cmd_rdy = (state_q == IDLE);

    always_comb begin
        outstd_d = outstd_q;
        if (ar_hs && !rl_hs) begin
            outstd_d = outstd_q + OUT_W'(1);
        end else if (!ar_hs && rl_hs) begin
            outstd_d = outstd_q - OUT_W'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        iss_addr_d = iss_addr_q;
        iss_rmn_d  = iss_rmn_q;
        rsp_rmn_d  = rsp_rmn_q;
        arvalid_d  = arvalid_q;
        araddr_d   = araddr_q;
        arlen_d    = arlen_q;
        err_d      = err_q;
        load       = 1'b0;
        page       = '0;
        lim        = '0;
        blen       = '0;

        if (r_hs && rsp_rmn_q != '0) begin
            rsp_rmn_d = rsp_rmn_q - WORD_NB_W'(1);
        end
        if (r_hs && rresp != 2'b00) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (cmd_vld) begin
                    iss_addr_d = cmd_addr & ~AXI4_ADD_W'(AXI4_DATA_BYTES - 1);
                    iss_rmn_d  = cmd_word_nb;
                    rsp_rmn_d  = cmd_word_nb;
                    err_d      = 1'b0;
                    if (cmd_word_nb != '0) begin
                        state_d = ISSUE;
                        load    = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (ar_hs) begin
                    iss_addr_d = iss_addr_q
                               + ((AXI4_ADD_W'(arlen_q) + AXI4_ADD_W'(1)) << SIZE);
                    iss_rmn_d  = iss_rmn_q
                               - (WORD_NB_W'(arlen_q) + WORD_NB_W'(1));
                end
                if (iss_rmn_d == '0) begin
                    state_d   = DRAIN;
                    arvalid_d = 1'b0;
                end else if (!arvalid_q || ar_hs) begin
                    load = 1'b1;
                end
            end
            DRAIN: begin
                if (rsp_rmn_d == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Next burst: clipped by remaining words, max length and 4KB page end
        if (load) begin
            page      = (13'd4096 - {1'b0, iss_addr_d[11:0]}) >> SIZE;
            lim       = (page < 13'(AXI4_LEN_MAX + 1)) ? page : 13'(AXI4_LEN_MAX + 1);
            blen      = (64'(iss_rmn_d) < 64'(lim)) ? 9'(iss_rmn_d) : 9'(lim);
            araddr_d  = iss_addr_d;
            arlen_d   = 8'(blen - 9'd1);
            arvalid_d = (outstd_d < OUT_W'(OUTSTD_MAX));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            iss_addr_q <= '0;
            iss_rmn_q  <= '0;
            rsp_rmn_q  <= '0;
            outstd_q   <= '0;
            arvalid_q  <= 1'b0;
            araddr_q   <= '0;
            arlen_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            iss_addr_q <= iss_addr_d;
            iss_rmn_q  <= iss_rmn_d;
            rsp_rmn_q  <= rsp_rmn_d;
            outstd_q   <= outstd_d;
            arvalid_q  <= arvalid_d;
            araddr_q   <= araddr_d;
            arlen_q    <= arlen_d;
            err_q      <= err_d;
        end
    end

    // Responses with no command in progress break the single-ID contract
    a_no_r_in_idle: assert property (@(posedge clk) disable iff (rst)
        !(rvalid && state_q == IDLE));

endmodule
